vproc_hazard_gate: RTL and testbench

// - Dispatch gate directly downstream of the per-instruction hazard-mask generator (rd/wr vreg bitmaps).
// - Holds one decoded instruction with its 32-bit read/write vreg masks and tracks in-flight vreg reads/writes.
// - Releases the instruction to the execution units only when it has no RAW, WAW or WAR conflict.
// - Units return per-vreg clear pulses; idle_o tells the decoder when vsetvl/fences may proceed.

---
 rtl/vproc_pkg.sv | 6 +
 rtl/vproc_rdcnt_array.sv | 27 ++
 rtl/vproc_hazard_gate.sv | 84 ++++++++
 tb/tb_vproc_hazard_gate.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vproc_pkg.sv
// vproc_pkg: shared vector-processor types and constants
package vproc_pkg;
  localparam int unsigned VREG_CNT = 32;
  typedef enum logic [2:0] {UNIT_LSU, UNIT_ALU, UNIT_MUL, UNIT_SLD, UNIT_ELEM} op_unit;
  typedef enum logic {BUF_EMPTY, BUF_HELD} buf_state_e;
endpackage

// File: rtl/vproc_rdcnt_array.sv
// vproc_rdcnt_array: per-vreg saturating up/down counters of outstanding readers
module vproc_rdcnt_array
  import vproc_pkg::*;
#(
  parameter int unsigned RDCNT_W = 2
) (
  input  logic                clk_i,
  input  logic                async_rst_ni,
  input  logic [VREG_CNT-1:0] inc,
  input  logic [VREG_CNT-1:0] dec,
  output logic [VREG_CNT-1:0] nz,
  output logic [VREG_CNT-1:0] at_max,
  output logic [VREG_CNT-1:0] eff_nz
);
  logic [RDCNT_W-1:0] cnt_q [VREG_CNT];
  for (genvar g = 0; g < VREG_CNT; g++) begin : g_cnt
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) cnt_q[g] <= '0;
      else if (inc[g] && !dec[g] && !at_max[g]) cnt_q[g] <= cnt_q[g] + 1'b1;
      else if (dec[g] && !inc[g] && nz[g]) cnt_q[g] <= cnt_q[g] - 1'b1;
    end
    assign nz[g]     = |cnt_q[g];
    assign at_max[g] = &cnt_q[g];
    // a reader finishing this cycle no longer blocks a writer
    assign eff_nz[g] = nz[g] && !(dec[g] && cnt_q[g] == RDCNT_W'(1));
  end
endmodule

// File: rtl/vproc_hazard_gate.sv
// vproc_hazard_gate: one-entry dispatch buffer that issues only when free of RAW/WAW/WAR hazards
module vproc_hazard_gate
  import vproc_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned RDCNT_W   = 2
) (
  input  logic                 clk_i,
  input  logic                 async_rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  input  op_unit               in_unit_i,
  input  logic [31:0]          in_rd_hazards_i,
  input  logic [31:0]          in_wr_hazards_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  output op_unit               out_unit_o,
  input  logic [31:0]          rd_clear_i,
  input  logic [31:0]          wr_clear_i,
  output logic [31:0]          pend_rd_o,
  output logic [31:0]          pend_wr_o,
  output logic                 idle_o
);
  buf_state_e           state_q;
  logic [PAYLOAD_W-1:0] pay_q;
  op_unit               unit_q;
  logic [31:0]          rd_m_q, wr_m_q, pend_wr_q, wr_eff, rd_eff, at_max, inc;
  logic                 hazard, issue, accept;

  vproc_rdcnt_array #(.RDCNT_W(RDCNT_W)) u_rdcnt (
    .clk_i        (clk_i),
    .async_rst_ni (async_rst_ni),
    .inc          (inc),
    .dec          (rd_clear_i),
    .nz           (pend_rd_o),
    .at_max       (at_max),
    .eff_nz       (rd_eff)
  );

  assign wr_eff = pend_wr_q & ~wr_clear_i;
  // own reads never block own writes; a full reader counter blocks further readers
  assign hazard = |(rd_m_q & wr_eff) | |(wr_m_q & wr_eff) | |(wr_m_q & rd_eff & ~rd_m_q)
                | |(rd_m_q & at_max & ~rd_clear_i);
  assign out_valid_o   = state_q == BUF_HELD && !hazard;
  assign issue         = out_valid_o && out_ready_i;
  assign in_ready_o    = state_q == BUF_EMPTY || issue;
  assign accept        = in_valid_i && in_ready_o;
  assign inc           = issue ? rd_m_q : '0;
  assign out_payload_o = pay_q;
  assign out_unit_o    = unit_q;
  assign pend_wr_o     = pend_wr_q;
  assign idle_o        = state_q == BUF_EMPTY && !(|pend_rd_o) && !(|pend_wr_q);

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q   <= BUF_EMPTY;
      pay_q     <= '0;
      unit_q    <= UNIT_LSU;
      rd_m_q    <= '0;
      wr_m_q    <= '0;
      pend_wr_q <= '0;
    end else begin
      pend_wr_q <= wr_eff | (issue ? wr_m_q : '0);
      if (accept) begin
        state_q <= BUF_HELD;
        pay_q   <= in_payload_i;
        unit_q  <= in_unit_i;
        rd_m_q  <= in_rd_hazards_i;
        wr_m_q  <= in_wr_hazards_i;
      end else if (issue) begin
        state_q <= BUF_EMPTY;
      end
    end
  end

  a_hold_stable: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
    out_valid_o && !out_ready_i |=> out_valid_o && $stable(out_payload_o));
  a_wr_clear: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
    (wr_clear_i & ~pend_wr_q) == '0);
  a_rd_clear: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
    (rd_clear_i & ~pend_rd_o) == '0);
endmodule

// File: tb/tb_vproc_hazard_gate.sv
// tb_vproc_hazard_gate: directed checks of issue gating, clears, saturation and reset
module tb_vproc_hazard_gate;
  import vproc_pkg::*;
  logic        clk_i = 0, async_rst_ni = 0;
  logic        in_valid_i = 0, in_ready_o, out_valid_o, out_ready_i = 1, idle_o;
  logic [63:0] in_payload_i = '0, out_payload_o;
  op_unit      in_unit_i = UNIT_LSU, out_unit_o;
  logic [31:0] in_rd_hazards_i = '0, in_wr_hazards_i = '0, rd_clear_i = '0, wr_clear_i = '0;
  logic [31:0] pend_rd_o, pend_wr_o;
  int checks = 0, failures = 0;

  vproc_hazard_gate dut (
    .clk_i(clk_i), .async_rst_ni(async_rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_payload_i(in_payload_i),
    .in_unit_i(in_unit_i), .in_rd_hazards_i(in_rd_hazards_i), .in_wr_hazards_i(in_wr_hazards_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_payload_o(out_payload_o),
    .out_unit_o(out_unit_o), .rd_clear_i(rd_clear_i), .wr_clear_i(wr_clear_i),
    .pend_rd_o(pend_rd_o), .pend_wr_o(pend_wr_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask

  task automatic put(input logic v, input logic [63:0] p, input op_unit u,
                     input logic [31:0] rd, input logic [31:0] wr);
    in_valid_i = v; in_payload_i = p; in_unit_i = u; in_rd_hazards_i = rd; in_wr_hazards_i = wr;
  endtask

  task automatic drop;
    put(0, '0, UNIT_LSU, '0, '0);
  endtask

  initial begin
    #3;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_ready", in_ready_o, 1);
    chk("rst_idle", idle_o, 1);
    chk("rst_pay", out_payload_o, 0);
    chk("rst_pend_rd", pend_rd_o, 0);
    chk("rst_pend_wr", pend_wr_o, 0);
    tick; async_rst_ni = 1; tick;
    // independent instructions issue back to back
    put(1, 64'hA1, UNIT_ALU, 32'h100, 32'h10); #1;
    chk("ind_rdy0", in_ready_o, 1);
    chk("ind_v0", out_valid_o, 0);
    tick;
    put(1, 64'hB2, UNIT_MUL, 32'h10000, 32'h1000); #1;
    chk("ind_issue_a", out_valid_o, 1);
    chk("ind_pay_a", out_payload_o, 64'hA1);
    chk("ind_unit_a", out_unit_o, UNIT_ALU);
    chk("ind_rdy_a", in_ready_o, 1);
    tick; drop; #1;
    chk("ind_issue_b", out_valid_o, 1);
    chk("ind_pay_b", out_payload_o, 64'hB2);
    chk("ind_pend_wr1", pend_wr_o, 32'h10);
    tick; #1;
    chk("ind_pend_wr2", pend_wr_o, 32'h1010);
    chk("ind_pend_rd2", pend_rd_o, 32'h10100);
    chk("ind_v_empty", out_valid_o, 0);
    chk("ind_busy", idle_o, 0);
    wr_clear_i = 32'h1010; rd_clear_i = 32'h10100;
    tick; wr_clear_i = 0; rd_clear_i = 0; #1;
    chk("ind_idle", idle_o, 1);
    // RAW: reader of v4 waits for the writer's clear
    put(1, 64'hC3, UNIT_ALU, 0, 32'h10); tick;
    put(1, 64'hD4, UNIT_ALU, 32'h10, 0); tick; drop; #1;
    chk("raw_hold1", out_valid_o, 0);
    chk("raw_pend_wr", pend_wr_o, 32'h10);
    tick; #1;
    chk("raw_hold2", out_valid_o, 0);
    chk("raw_rdy_held", in_ready_o, 0);
    tick; wr_clear_i = 32'h10; #1;
    chk("raw_release", out_valid_o, 1);
    tick; wr_clear_i = 0; #1;
    chk("raw_pend_wr0", pend_wr_o, 0);
    chk("raw_pend_rd", pend_rd_o, 32'h10);
    chk("raw_v_empty", out_valid_o, 0);
    rd_clear_i = 32'h10; tick; rd_clear_i = 0; #1;
    chk("raw_idle", idle_o, 1);
    // WAR: writer of v2 waits for the outstanding reader
    put(1, 64'hE5, UNIT_MUL, 32'h4, 32'h400); tick;
    put(1, 64'hF6, UNIT_MUL, 0, 32'h4); tick; drop; #1;
    chk("war_hold1", out_valid_o, 0);
    chk("war_pend_rd", pend_rd_o, 32'h4);
    tick; #1;
    chk("war_hold2", out_valid_o, 0);
    rd_clear_i = 32'h4; #1;
    chk("war_release", out_valid_o, 1);
    tick; rd_clear_i = 0; #1;
    chk("war_pend_wr", pend_wr_o, 32'h404);
    chk("war_pend_rd0", pend_rd_o, 0);
    wr_clear_i = 32'h404; tick; wr_clear_i = 0;
    put(1, 64'h77, UNIT_ALU, 32'h4, 32'h4); tick; drop; #1;
    chk("self_no_stall", out_valid_o, 1);
    tick; #1;
    chk("self_pend_rd", pend_rd_o, 32'h4);
    chk("self_pend_wr", pend_wr_o, 32'h4);
    rd_clear_i = 32'h4; wr_clear_i = 32'h4; tick; rd_clear_i = 0; wr_clear_i = 0; #1;
    chk("self_idle", idle_o, 1);
    // saturation: fourth reader of v1 stalls at count 3
    for (int i = 0; i < 4; i++) begin
      put(1, 64'h100 + 64'(i), UNIT_SLD, 32'h2, 0); tick;
    end
    drop; #1;
    chk("sat_stall", out_valid_o, 0);
    chk("sat_pay", out_payload_o, 64'h103);
    chk("sat_pend_rd", pend_rd_o, 32'h2);
    tick; #1;
    chk("sat_stall2", out_valid_o, 0);
    rd_clear_i = 32'h2; #1;
    chk("sat_release", out_valid_o, 1);
    tick; tick; tick; rd_clear_i = 0; #1;
    chk("sat_nowrap", pend_rd_o, 32'h2);
    chk("sat_busy", idle_o, 0);
    rd_clear_i = 32'h2; tick; rd_clear_i = 0; #1;
    chk("sat_drained", pend_rd_o, 0);
    chk("sat_idle", idle_o, 1);
    // new writer issues on the same cycle the old writer clears
    put(1, 64'h55, UNIT_ALU, 0, 32'h40); tick;
    put(1, 64'h66, UNIT_ALU, 0, 32'h40); tick; drop; #1;
    chk("sim_hold", out_valid_o, 0);
    wr_clear_i = 32'h40; #1;
    chk("sim_release", out_valid_o, 1);
    tick; wr_clear_i = 0; #1;
    chk("sim_pend_wr", pend_wr_o, 32'h40);
    wr_clear_i = 32'h40; tick; wr_clear_i = 0; #1;
    chk("sim_idle", idle_o, 1);
    // backpressure then asynchronous reset while holding
    out_ready_i = 0;
    put(1, 64'hDEAD, UNIT_MUL, 32'h8, 32'h20); tick;
    put(1, 64'hBEEF, UNIT_LSU, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", out_valid_o, 1);
      chk("bp_pay", out_payload_o, 64'hDEAD);
      chk("bp_unit", out_unit_o, UNIT_MUL);
      chk("bp_rdy", in_ready_o, 0);
      tick;
    end
    #1 async_rst_ni = 0; drop;
    tick; #1;
    chk("arst_valid", out_valid_o, 0);
    chk("arst_idle", idle_o, 1);
    chk("arst_pend_rd", pend_rd_o, 0);
    chk("arst_pend_wr", pend_wr_o, 0);
    chk("arst_pay", out_payload_o, 0);
    async_rst_ni = 1; out_ready_i = 1; tick; #1;
    chk("post_rst_rdy", in_ready_o, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
